// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

   localparam int XLEN    = 32;
   localparam int COUNT_W = $clog2(XLEN);

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One iteration of shift-add multiply or restoring divide over a {hi,lo}
// register pair; purely combinational.
module muldiv_datapath
#(
   parameter int WIDTH = 32
)(
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_addend;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // Multiply: hi accumulates, lo holds the unconsumed multiplier bits.
   // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      w_addend = i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}};
      w_sum    = {1'b0, i_hi} + w_addend;
      w_shift  = {i_hi, i_lo[WIDTH-1]};
      w_diff   = w_shift - {1'b0, i_opnd};
      if (i_is_div) begin
         if (!w_diff[WIDTH]) begin
            o_hi = w_diff[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b1};
         end else begin
            o_hi = w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: stalls the core for WIDTH cycles
// (or one cycle on divide special cases) and issues a single writeback pulse.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        funct3,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              busy,
   output logic              done,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [WIDTH-1:0]  wb_data
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t              r_state, w_state_nxt;
   logic [COUNT_W-1:0]  r_count;
   logic [2:0]          r_f3;
   logic [ADDR_W-1:0]   r_rd;
   logic                r_neg;
   logic [WIDTH-1:0]    r_hi, r_lo, r_opnd;
   logic                r_busy, r_done, r_wb_en;
   logic [ADDR_W-1:0]   r_wb_addr;
   logic [WIDTH-1:0]    r_wb_data;

   logic                w_accept, w_finish;
   logic                w_neg_a, w_neg_b, w_div_zero, w_ovf, w_special, w_res_neg;
   logic [WIDTH-1:0]    w_mag_a, w_mag_b, w_special_res;
   logic [WIDTH-1:0]    w_hi_nxt, w_lo_nxt;
   logic [2*WIDTH-1:0]  w_prod, w_prod_fix;
   logic [WIDTH-1:0]    w_div_val, w_div_fix, w_result;
   logic                w_load;
   logic [ADDR_W-1:0]   w_load_addr;
   logic [WIDTH-1:0]    w_load_data;

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .i_is_div (r_f3[2]),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .i_opnd   (r_opnd),
      .o_hi     (w_hi_nxt),
      .o_lo     (w_lo_nxt)
   );

   // Operand magnitudes, result sign and divide special cases at accept.
   always_comb begin
      w_neg_a    = a_is_signed(funct3) & op_a[WIDTH-1];
      w_neg_b    = b_is_signed(funct3) & op_b[WIDTH-1];
      w_mag_a    = w_neg_a ? (ZERO_W - op_a) : op_a;
      w_mag_b    = w_neg_b ? (ZERO_W - op_b) : op_b;
      w_res_neg  = (funct3[2] & funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
      w_div_zero = funct3[2] & (op_b == ZERO_W);
      w_ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == MIN_W) && (op_b == ONES_W);
      w_special  = w_div_zero | w_ovf;
      if (w_div_zero) begin
         w_special_res = funct3[1] ? op_a : ONES_W;
      end else begin
         w_special_res = funct3[1] ? ZERO_W : op_a;
      end
   end

   // Final sign fix-up on the last iteration's output.
   always_comb begin
      w_prod     = {w_hi_nxt, w_lo_nxt};
      w_prod_fix = r_neg ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
      w_div_val  = r_f3[1] ? w_hi_nxt : w_lo_nxt;
      w_div_fix  = r_neg ? (ZERO_W - w_div_val) : w_div_val;
      case (r_f3)
         F3_MUL:                       w_result = w_prod_fix[WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
         default:                      w_result = w_div_fix;
      endcase
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = w_special ? DONE : CALC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            if (r_count == COUNT_W'(WIDTH-1)) begin
               w_finish    = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = CALC;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Writeback source: special-case result at accept, or computed result on finish.
   always_comb begin
      w_load      = 1'b0;
      w_load_addr = r_wb_addr;
      w_load_data = r_wb_data;
      if (w_accept && w_special) begin
         w_load      = 1'b1;
         w_load_addr = rd_addr;
         w_load_data = w_special_res;
      end else if (w_finish) begin
         w_load      = 1'b1;
         w_load_addr = r_rd;
         w_load_data = w_result;
      end else begin
         w_load      = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operation context and iteration registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= {COUNT_W{1'b0}};
         r_f3    <= 3'b000;
         r_rd    <= {ADDR_W{1'b0}};
         r_neg   <= 1'b0;
         r_hi    <= ZERO_W;
         r_lo    <= ZERO_W;
         r_opnd  <= ZERO_W;
      end else if (w_accept) begin
         r_count <= {COUNT_W{1'b0}};
         r_f3    <= funct3;
         r_rd    <= rd_addr;
         r_neg   <= w_res_neg;
         r_hi    <= ZERO_W;
         r_lo    <= funct3[2] ? w_mag_a : w_mag_b;
         r_opnd  <= funct3[2] ? w_mag_b : w_mag_a;
      end else if (r_state == CALC) begin
         r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   // Registered core-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= {ADDR_W{1'b0}};
         r_wb_data <= ZERO_W;
      end else begin
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= w_load;
         r_wb_en   <= w_load && (w_load_addr != {ADDR_W{1'b0}});
         r_wb_addr <= w_load_addr;
         r_wb_data <= w_load_data;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign wb_en   = r_wb_en;
   assign wb_addr = r_wb_addr;
   assign wb_data = r_wb_data;

endmodule
